// File: rtl/web_fire_controller.sv
// web_fire_controller: sequences one web-shooter command at a time against fluid/energy/tracer stores.
// Optional feature macro WEB_RECHARGE_EN: slow energy recharge while idle.
module web_fire_controller #(
  parameter int unsigned INIT_ENERGY     = 100,
  parameter int unsigned INIT_FLUID      = 15,
  parameter int unsigned INIT_TRACERS    = 32,
  parameter int unsigned RAPID_BURST     = 3,
  parameter int unsigned COOLDOWN_CYC    = 4,
  parameter int unsigned RECHARGE_PERIOD = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req_valid,
  input  logic [2:0] i_req_sel,
  output logic       o_req_ready,
  input  logic       i_load_en,
  input  logic [7:0] i_load_energy,
  input  logic [3:0] i_load_fluid,
  input  logic [5:0] i_load_tracers,
  output logic       o_fire_pulse,
  output logic       o_done_valid,
  output logic       o_done_ok,
  output logic       o_busy,
  output logic [7:0] o_energy_out,
  output logic [3:0] o_fluid_out,
  output logic [5:0] o_tracers_out
);

  localparam int unsigned      CoolW    = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;
  localparam bit               HasCool  = (COOLDOWN_CYC != 0);
  localparam logic [CoolW-1:0] CoolLoad = CoolW'(COOLDOWN_CYC - 1);

  typedef enum logic [2:0] {StIdle, StCheck, StExec, StDeny, StCool} state_t;

  state_t           r_state;
  logic [2:0]       r_sel;
  logic [2:0]       r_shots;
  logic             r_fired;
  logic [CoolW-1:0] r_cool;
  logic [7:0]       r_energy;
  logic [3:0]       r_fluid;
  logic [5:0]       r_tracers;
  logic             r_fire_pulse;
  logic             r_done_valid;
  logic             r_done_ok;

  logic [3:0]       w_cost_fluid;
  logic [7:0]       w_cost_energy;
  logic [5:0]       w_cost_tracers;
  logic             w_ok;

`ifdef WEB_RECHARGE_EN
  localparam int unsigned RechW = (RECHARGE_PERIOD > 1) ? $clog2(RECHARGE_PERIOD) : 1;
  logic [RechW-1:0] r_rech_cnt;
  logic             w_rech_tick;
  assign w_rech_tick = (r_rech_cnt == RechW'(RECHARGE_PERIOD - 1));
`endif

  always_comb begin
    w_cost_fluid   = '0;
    w_cost_energy  = '0;
    w_cost_tracers = '0;
    case (r_sel)
      3'd1: begin w_cost_fluid = 4'd1;  w_cost_energy = 8'd1;  end
      3'd2: begin w_cost_fluid = 4'd1;  w_cost_energy = 8'd2;  end
      3'd3: begin w_cost_fluid = 4'd15; w_cost_energy = 8'd4;  end
      3'd4: begin w_cost_fluid = 4'd1;  w_cost_energy = 8'd16; w_cost_tracers = 6'd8; end
      3'd5: begin w_cost_fluid = 4'd1;  w_cost_energy = 8'd1;  end
      3'd6: begin w_cost_fluid = 4'd1;  w_cost_energy = 8'd1;  w_cost_tracers = 6'd4; end
      default: ;
    endcase
  end

  // Reload (sel 0) costs nothing so it always passes; nop (sel 7) always denies.
  assign w_ok = (r_sel != 3'd7) && (r_fluid >= w_cost_fluid) &&
                (r_energy >= w_cost_energy) && (r_tracers >= w_cost_tracers);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_sel        <= '0;
      r_shots      <= '0;
      r_fired      <= 1'b0;
      r_cool       <= '0;
      r_energy     <= 8'(INIT_ENERGY);
      r_fluid      <= 4'(INIT_FLUID);
      r_tracers    <= 6'(INIT_TRACERS);
      r_fire_pulse <= 1'b0;
      r_done_valid <= 1'b0;
      r_done_ok    <= 1'b0;
`ifdef WEB_RECHARGE_EN
      r_rech_cnt   <= '0;
`endif
    end else begin
      r_fire_pulse <= 1'b0;
      r_done_valid <= 1'b0;
      r_done_ok    <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_load_en) begin
            r_energy  <= i_load_energy;
            r_fluid   <= i_load_fluid;
            r_tracers <= i_load_tracers;
          end else begin
`ifdef WEB_RECHARGE_EN
            if (w_rech_tick) begin
              r_rech_cnt <= '0;
              if (r_energy != 8'hFF) r_energy <= r_energy + 8'd1;
            end else begin
              r_rech_cnt <= r_rech_cnt + 1'b1;
            end
`endif
            if (i_req_valid) begin
              r_sel   <= i_req_sel;
              r_shots <= (i_req_sel == 3'd5) ? 3'(RAPID_BURST) : 3'd1;
              r_fired <= 1'b0;
              r_state <= StCheck;
            end
          end
        end
        StCheck: r_state <= w_ok ? StExec : StDeny;
        StExec: begin
          if (r_sel == 3'd0) begin
            r_fluid <= 4'hF;
          end else begin
            r_fluid      <= r_fluid - w_cost_fluid;
            r_energy     <= r_energy - w_cost_energy;
            r_tracers    <= r_tracers - w_cost_tracers;
            r_fire_pulse <= 1'b1;
            r_fired      <= 1'b1;
          end
          r_shots <= r_shots - 3'd1;
          if (r_shots > 3'd1) begin
            r_state <= StCheck;
          end else begin
            r_done_valid <= 1'b1;
            r_done_ok    <= 1'b1;
            r_state      <= HasCool ? StCool : StIdle;
            r_cool       <= CoolLoad;
          end
        end
        StDeny: begin
          r_done_valid <= 1'b1;
          r_done_ok    <= r_fired;
          r_state      <= HasCool ? StCool : StIdle;
          r_cool       <= CoolLoad;
        end
        StCool: begin
          if (r_cool == '0) r_state <= StIdle;
          else              r_cool  <= r_cool - 1'b1;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_req_ready   = (r_state == StIdle) && !i_load_en;
  assign o_busy        = (r_state != StIdle);
  assign o_fire_pulse  = r_fire_pulse;
  assign o_done_valid  = r_done_valid;
  assign o_done_ok     = r_done_ok;
  assign o_energy_out  = r_energy;
  assign o_fluid_out   = r_fluid;
  assign o_tracers_out = r_tracers;

endmodule

// File: tb/tb_web_fire_controller.sv
// Self-checking bench for web_fire_controller: directed vector table, hand sequences, random vs model.
module tb_web_fire_controller;
  localparam int Cool = 4;
`ifdef WEB_RECHARGE_EN
  localparam int ETol = 1;
`else
  localparam int ETol = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [2:0] req_sel = '0;
  logic       load_en = 1'b0;
  logic [7:0] load_energy = '0;
  logic [3:0] load_fluid = '0;
  logic [5:0] load_tracers = '0;
  logic       req_ready, fire_pulse, done_valid, done_ok, busy;
  logic [7:0] energy;
  logic [3:0] fluid;
  logic [5:0] tracers;

  int checks = 0;
  int errors = 0;

  web_fire_controller dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req_valid   (req_valid),
    .i_req_sel     (req_sel),
    .o_req_ready   (req_ready),
    .i_load_en     (load_en),
    .i_load_energy (load_energy),
    .i_load_fluid  (load_fluid),
    .i_load_tracers(load_tracers),
    .o_fire_pulse  (fire_pulse),
    .o_done_valid  (done_valid),
    .o_done_ok     (done_ok),
    .o_busy        (busy),
    .o_energy_out  (energy),
    .o_fluid_out   (fluid),
    .o_tracers_out (tracers)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lf, le, lt, sel;
    int fires, ok, off;
    int ef, ee, et;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Energy compare; with recharge the accept edge may add one unit.
  task automatic chk_e(input string name, input int act, input int exp);
    checks++;
    if (act < exp || act > exp + ETol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, exp, exp + ETol);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int f, input int e, input int t);
    load_en = 1'b1;
    load_fluid = 4'(f);
    load_energy = 8'(e);
    load_tracers = 6'(t);
    tick();
    load_en = 1'b0;
  endtask

  function automatic void model(input int sel, input int f, input int e, input int t,
                                output int fires, output int ok, output int off,
                                output int nf, output int ne, output int nt);
    int cf, ce, ct, n, aff;
    cf = 0; ce = 0; ct = 0;
    nf = f; ne = e; nt = t;
    n = (sel == 5) ? 3 : 1;
    case (sel)
      1: begin cf = 1;  ce = 1;  end
      2: begin cf = 1;  ce = 2;  end
      3: begin cf = 15; ce = 4;  end
      4: begin cf = 1;  ce = 16; ct = 8; end
      5: begin cf = 1;  ce = 1;  end
      6: begin cf = 1;  ce = 1;  ct = 4; end
      default: ;
    endcase
    if (sel == 0) begin
      fires = 0; ok = 1; off = 2; nf = 15;
    end else if (sel == 7) begin
      fires = 0; ok = 0; off = 2;
    end else begin
      aff = n;
      if (f / cf < aff) aff = f / cf;
      if (e / ce < aff) aff = e / ce;
      if (ct > 0 && t / ct < aff) aff = t / ct;
      fires = aff;
      ok = (fires > 0) ? 1 : 0;
      off = (fires == n) ? 2 * n : 2 + 2 * fires;
      nf = f - fires * cf;
      ne = e - fires * ce;
      nt = t - fires * ct;
    end
  endfunction

  // Issue one command and observe it until the block is idle again.
  task automatic run_cmd(input int sel, output int fires, output int ok, output int off,
                         output int dones, output int coolbusy);
    fires = 0; ok = 0; off = 0; dones = 0; coolbusy = 0;
    #1;
    chk("ready_before_req", int'(req_ready), 1);
    req_valid = 1'b1;
    req_sel = 3'(sel);
    tick();
    for (int c = 1; c <= 80; c++) begin
      req_valid = (c <= 2);  // requests while busy must be ignored
      req_sel = 3'($urandom);
      tick();
      if (fire_pulse) fires++;
      if (done_valid) begin
        dones++;
        if (dones == 1) begin
          off = c;
          ok = int'(done_ok);
        end
      end
      if (dones > 0) begin
        if (busy) coolbusy++;
        else break;
      end
    end
    req_valid = 1'b0;
    if (dones == 0 || busy) chk("cmd_timeout", 0, 1);
  endtask

  task automatic reset_mid(input int wait_cyc, input string tag);
    int bad;
    do_load(5, 50, 10);
    req_valid = 1'b1;
    req_sel = 3'd1;
    tick();
    req_valid = 1'b0;
    repeat (wait_cyc) tick();
    #2 rst = 1'b1;
    #1;
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_ready"}, int'(req_ready), 1);
    chk({tag, "_fluid"}, int'(fluid), 15);
    chk({tag, "_energy"}, int'(energy), 100);
    chk({tag, "_tracers"}, int'(tracers), 32);
    tick();
    tick();
    rst = 1'b0;
    bad = 0;
    repeat (6) begin
      tick();
      if (done_valid || fire_pulse || busy) bad++;
    end
    chk({tag, "_no_done"}, bad, 0);
  endtask

  initial begin
    int fires, ok, off, dones, cb;
    int mf, mok, moff, nf, ne, nt;
    int f, e, t, sel, bad;

    tbl[0]  = '{15, 100, 32, 3, 1, 1, 2, 0, 96, 32};
    tbl[1]  = '{0, 96, 32, 1, 0, 0, 2, 0, 96, 32};
    tbl[2]  = '{2, 100, 32, 5, 2, 1, 6, 0, 98, 32};
    tbl[3]  = '{15, 100, 7, 4, 0, 0, 2, 15, 100, 7};
    tbl[4]  = '{15, 100, 8, 4, 1, 1, 2, 14, 84, 0};
    tbl[5]  = '{14, 84, 0, 0, 0, 1, 2, 15, 84, 0};
    tbl[6]  = '{15, 84, 0, 7, 0, 0, 2, 15, 84, 0};
    tbl[7]  = '{1, 100, 32, 5, 1, 1, 4, 0, 99, 32};
    tbl[8]  = '{15, 100, 3, 6, 0, 0, 2, 15, 100, 3};
    tbl[9]  = '{15, 100, 4, 6, 1, 1, 2, 14, 99, 0};
    tbl[10] = '{15, 100, 32, 5, 3, 1, 6, 12, 97, 32};
    tbl[11] = '{1, 100, 32, 2, 1, 1, 2, 0, 98, 32};
    tbl[12] = '{14, 100, 32, 3, 0, 0, 2, 14, 100, 32};

    // Reset state
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("rst_energy", int'(energy), 100);
    chk("rst_fluid", int'(fluid), 15);
    chk("rst_tracers", int'(tracers), 32);
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_fire", int'(fire_pulse), 0);
    chk("rst_done_valid", int'(done_valid), 0);
    chk("rst_done_ok", int'(done_ok), 0);

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      do_load(tbl[i].lf, tbl[i].le, tbl[i].lt);
      run_cmd(tbl[i].sel, fires, ok, off, dones, cb);
      chk($sformatf("tbl%0d_fires", i), fires, tbl[i].fires);
      chk($sformatf("tbl%0d_ok", i), ok, tbl[i].ok);
      chk($sformatf("tbl%0d_latency", i), off, tbl[i].off);
      chk($sformatf("tbl%0d_dones", i), dones, 1);
      chk($sformatf("tbl%0d_cooldown", i), cb, Cool);
      chk($sformatf("tbl%0d_fluid", i), int'(fluid), tbl[i].ef);
      chk_e($sformatf("tbl%0d_energy", i), int'(energy), tbl[i].ee);
      chk($sformatf("tbl%0d_tracers", i), int'(tracers), tbl[i].et);
    end

    // load_en blocks a same-cycle request and wins
    load_en = 1'b1;
    load_fluid = 4'd9;
    load_energy = 8'd77;
    load_tracers = 6'd20;
    req_valid = 1'b1;
    req_sel = 3'd1;
    #1;
    chk("load_blocks_ready", int'(req_ready), 0);
    tick();
    load_en = 1'b0;
    req_valid = 1'b0;
    chk("load_fluid", int'(fluid), 9);
    chk("load_energy", int'(energy), 77);
    chk("load_tracers", int'(tracers), 20);
    bad = 0;
    repeat (3) begin
      tick();
      if (busy || done_valid) bad++;
    end
    chk("load_no_accept", bad, 0);

    // load_en while busy is ignored
    req_valid = 1'b1;
    req_sel = 3'd7;
    tick();
    req_valid = 1'b0;
    load_en = 1'b1;
    load_fluid = 4'd1;
    load_energy = 8'd1;
    load_tracers = 6'd1;
    repeat (3) tick();
    load_en = 1'b0;
    for (int c = 0; c < 20 && busy; c++) tick();
    chk("busy_load_idle", int'(busy), 0);
    chk("busy_load_fluid", int'(fluid), 9);
    chk_e("busy_load_energy", int'(energy), 77);
    chk("busy_load_tracers", int'(tracers), 20);

`ifdef WEB_RECHARGE_EN
    do_load(3, 10, 5);
    repeat (32) tick();
    chk("recharge_energy", int'(energy), 14);
    do_load(3, 255, 5);
    repeat (20) tick();
    chk("recharge_saturate", int'(energy), 255);
`else
    do_load(3, 50, 5);
    repeat (40) tick();
    chk("idle_energy_stable", int'(energy), 50);
`endif

    // Asynchronous reset mid-command
    reset_mid(1, "rst_exec");
    reset_mid(3, "rst_cool");

    // Random commands against the reference model
    for (int i = 0; i < 40; i++) begin
      f = $urandom_range(0, 15);
`ifdef WEB_RECHARGE_EN
      e = $urandom_range(20, 60);
`else
      e = $urandom_range(0, 40);
`endif
      t = $urandom_range(0, 15);
      sel = $urandom_range(0, 7);
      do_load(f, e, t);
      model(sel, f, e, t, mf, mok, moff, nf, ne, nt);
      run_cmd(sel, fires, ok, off, dones, cb);
      chk($sformatf("rnd%0d_sel%0d_fires", i, sel), fires, mf);
      chk($sformatf("rnd%0d_sel%0d_ok", i, sel), ok, mok);
      chk($sformatf("rnd%0d_sel%0d_latency", i, sel), off, moff);
      chk($sformatf("rnd%0d_sel%0d_dones", i, sel), dones, 1);
      chk($sformatf("rnd%0d_sel%0d_cooldown", i, sel), cb, Cool);
      chk($sformatf("rnd%0d_sel%0d_fluid", i, sel), int'(fluid), nf);
      chk_e($sformatf("rnd%0d_sel%0d_energy", i, sel), int'(energy), ne);
      chk($sformatf("rnd%0d_sel%0d_tracers", i, sel), int'(tracers), nt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
